// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit_serializer slice.
package bit_serializer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2
  } ser_state_t;

  localparam int SER_WIDTH_DEFAULT = 8;

  function automatic int ser_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry holding register between the parallel source and the shifter.
module ser_hold_buf
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_i,
  input  logic             load_i,
  input  logic             drain_i,
  output logic [WIDTH-1:0] hold_data_o,
  output logic             hold_full_o,
  output logic             din_ready_o
);

  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (drain_i) begin
      hold_full_q <= 1'b0;
    end else if (load_i) begin
      hold_q      <= din_i;
      hold_full_q <= 1'b1;
    end
  end

  assign hold_data_o = hold_q;
  assign hold_full_o = hold_full_q;
  assign din_ready_o = !hold_full_q && !rst;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end, MSB first, with a one-word holding buffer.
// Optional trailing even-parity bit when BIT_SERIALIZER_PARITY_EN is defined.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int            CW     = ser_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam bit LAST_IS_DATA = 1'b0;
`else
  localparam bit LAST_IS_DATA = 1'b1;
`endif

  ser_state_t       state_q;
  logic [WIDTH-1:0] sh_q;
  logic [CW-1:0]    cnt_q;
  logic             sout_q, sout_valid_q, word_done_q;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             par_q;
`endif

  logic [WIDTH-1:0] hold_data, word_d;
  logic             hold_full, accept, end_word, start_word, buf_load, buf_drain;

  assign accept = din_valid && din_ready;

  // end_word marks the edge that retires the bit currently on sout as the word's last
`ifdef BIT_SERIALIZER_PARITY_EN
  assign end_word = (state_q == S_PAR);
`else
  assign end_word = (state_q == S_SHIFT) && (cnt_q == LAST);
`endif

  assign start_word = ((state_q == S_IDLE) && accept) || (end_word && (hold_full || accept));
  assign buf_load   = accept && (state_q != S_IDLE) && !end_word;
  assign buf_drain  = end_word && hold_full;
  assign word_d     = buf_drain ? hold_data : din;

  ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk         (clk),
    .rst         (rst),
    .din_i       (din),
    .load_i      (buf_load),
    .drain_i     (buf_drain),
    .hold_data_o (hold_data),
    .hold_full_o (hold_full),
    .din_ready_o (din_ready)
  );

  // Output registers are loaded with the bit they present in the following cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sh_q         <= '0;
      cnt_q        <= '0;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      word_done_q  <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else if (start_word) begin
      state_q      <= S_SHIFT;
      sh_q         <= {word_d[WIDTH-2:0], 1'b0};
      cnt_q        <= '0;
      sout_q       <= word_d[WIDTH-1];
      sout_valid_q <= 1'b1;
      word_done_q  <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q        <= ^word_d;
`endif
    end else if (end_word) begin
      state_q      <= S_IDLE;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      word_done_q  <= 1'b0;
    end else if (state_q == S_SHIFT) begin
`ifdef BIT_SERIALIZER_PARITY_EN
      if (cnt_q == LAST) begin
        state_q     <= S_PAR;
        sout_q      <= par_q;
        word_done_q <= 1'b1;
      end else begin
        sout_q      <= sh_q[WIDTH-1];
        sh_q        <= sh_q << 1;
        cnt_q       <= cnt_q + CW'(1);
        word_done_q <= LAST_IS_DATA && (cnt_q == PENULT);
      end
`else
      sout_q      <= sh_q[WIDTH-1];
      sh_q        <= sh_q << 1;
      cnt_q       <= cnt_q + CW'(1);
      word_done_q <= LAST_IS_DATA && (cnt_q == PENULT);
`endif
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign word_done  = word_done_q;
  assign busy       = sout_valid_q | hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: bit-queue reference model plus directed literal checks.
module tb_bit_serializer;

  localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int L = W + 1;
  localparam logic [L-1:0]   EXP_B0   = 9'b10110000_1;
  localparam logic [2*L-1:0] EXP_B2B  = 18'b10100101_0_00111100_0;
  localparam logic [2*L-1:0] EXP_BYP  = 18'b10100101_0_11000011_0;
`else
  localparam int L = W;
  localparam logic [L-1:0]   EXP_B0   = 8'hB0;
  localparam logic [2*L-1:0] EXP_B2B  = 16'hA53C;
  localparam logic [2*L-1:0] EXP_BYP  = 16'hA5C3;
`endif

  logic clk = 1'b0;
  logic rst, din_valid, din_ready, sout, sout_valid, word_done, busy;
  logic [W-1:0] din;

  int errors = 0;
  int checks = 0;
  bit en = 1'b0;

  // Reference: every accepted word appends its bits; one bit leaves per cycle.
  bit [1:0] mq[$];   // {done, value}

  typedef struct packed {logic s, v, d, b, r;} obs_t;
  obs_t tr[$];

  bit_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .word_done  (word_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit [1:0] wbit(input logic [W-1:0] d, input int i);
    bit v;
    v = (i < W) ? d[W-1-i] : ^d;
    return {bit'(i == L - 1), v};
  endfunction

  always @(posedge clk) begin
    if (rst) mq.delete();
    else begin
      bit acc;
      acc = din_valid && (mq.size() <= L);
      if (mq.size() > 0) void'(mq.pop_front());
      if (acc) for (int i = 0; i < L; i++) mq.push_back(wbit(din, i));
    end
  end

  bit [1:0] e_cur;
  bit       e_vld, e_rdy;
  always @(negedge clk) begin
    #2;
    if (en) begin
      e_vld = mq.size() > 0;
      e_cur = e_vld ? mq[0] : 2'b00;
      e_rdy = !rst && (mq.size() <= L);
      chk("sout",       sout,       e_cur[0]);
      chk("sout_valid", sout_valid, e_vld);
      chk("word_done",  word_done,  e_cur[1]);
      chk("busy",       busy,       e_vld);
      chk("din_ready",  din_ready,  e_rdy);
      tr.push_back('{sout, sout_valid, word_done, busy, din_ready});
    end
  end

  task automatic cyc(input logic r, input logic v, input logic [W-1:0] d, input bit clr);
    @(negedge clk);
    if (clr) tr.delete();
    rst = r; din_valid = v; din = d;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, '0, 1'b0);
  endtask

  logic [L-1:0]   e1;
  logic [2*L-1:0] e2;
  bit             found;
  int             mode;

  initial begin
    rst = 1'b1; din_valid = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    en = 1'b1;

    // Reset state and no acceptance while rst is high
    cyc(1'b1, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b1, 8'hAA, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    #3;
    chk("rst_ready", tr[0].r, 0);
    chk("rst_valid", tr[0].v, 0);
    chk("rst_busy",  tr[0].b, 0);
    chk("rst_ready_vin", tr[1].r, 0);
    chk("post_rst_ready", tr[2].r, 1);
    chk("post_rst_valid", tr[2].v, 0);

    // Single word 0xB0
    e1 = EXP_B0;
    cyc(1'b0, 1'b1, 8'hB0, 1'b1);
    idle(L + 3);
    #3;
    for (int k = 1; k <= L; k++) chk("b0_bit", tr[k].s, e1[L-k]);
    for (int k = 1; k <= L + 2; k++) begin
      chk("b0_valid", tr[k].v, k <= L);
      chk("b0_done",  tr[k].d, k == L);
    end
    chk("b0_busy_end", tr[L+1].b, 0);
    found = 1'b0;
    for (int k = 1; k + 3 <= L; k++)
      if ({tr[k].s, tr[k+1].s, tr[k+2].s, tr[k+3].s} == 4'b1011) found = 1'b1;
    chk("b0_detect_1011", found, 1);

    // Back-to-back 0xA5, 0x3C
    e2 = EXP_B2B;
    cyc(1'b0, 1'b1, 8'hA5, 1'b1);
    cyc(1'b0, 1'b1, 8'h3C, 1'b0);
    idle(2 * L + 2);
    #3;
    for (int k = 1; k <= 2 * L; k++) chk("b2b_bit", tr[k].s, e2[2*L-k]);
    for (int k = 1; k <= 2 * L + 1; k++) begin
      chk("b2b_valid", tr[k].v, k <= 2 * L);
      chk("b2b_done",  tr[k].d, (k == L) || (k == 2 * L));
    end
    chk("b2b_full_ready", tr[2].r, 0);

    // Second word presented exactly on the last-bit cycle (bypass)
    e2 = EXP_BYP;
    cyc(1'b0, 1'b1, 8'hA5, 1'b1);
    idle(L - 1);
    cyc(1'b0, 1'b1, 8'hC3, 1'b0);
    idle(L + 2);
    #3;
    for (int k = 1; k <= 2 * L; k++) begin
      chk("byp_bit",   tr[k].s, e2[2*L-k]);
      chk("byp_valid", tr[k].v, 1);
    end
    chk("byp_ready_last", tr[L].r, 1);

    // Reset after 3 bits of 0xFF with 0x0F buffered
    cyc(1'b0, 1'b1, 8'hFF, 1'b1);
    cyc(1'b0, 1'b1, 8'h0F, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, '0, 1'b0);
    idle(2 * L + 2);
    #3;
    for (int k = 1; k <= 3; k++) chk("rstmid_bit", tr[k].s, 1);
    chk("rstmid_full", tr[2].r, 0);
    chk("rstmid_sout", tr[4].s, 0);
    chk("rstmid_ready", tr[4].r, 1);
    for (int k = 4; k < tr.size(); k++) chk("rstmid_novalid", tr[k].v, 0);
    for (int k = 1; k < tr.size(); k++) chk("rstmid_nodone", tr[k].d, 0);

    // Idle line
    cyc(1'b0, 1'b0, '0, 1'b1);
    idle(20);
    #3;
    for (int k = 1; k <= 20; k++) begin
      chk("idle_sout",  tr[k].s, 0);
      chk("idle_valid", tr[k].v, 0);
      chk("idle_busy",  tr[k].b, 0);
      chk("idle_ready", tr[k].r, 1);
    end

`ifdef BIT_SERIALIZER_PARITY_EN
    e1 = 9'b00000111_1;
    cyc(1'b0, 1'b1, 8'h07, 1'b1);
    idle(L + 1);
    #3;
    for (int k = 1; k <= L; k++) begin
      chk("p07_bit",  tr[k].s, e1[L-k]);
      chk("p07_done", tr[k].d, k == L);
    end
    e1 = 9'b00000011_0;
    cyc(1'b0, 1'b1, 8'h03, 1'b1);
    idle(L + 1);
    #3;
    for (int k = 1; k <= L; k++) chk("p03_bit", tr[k].s, e1[L-k]);
`endif

    // Randomized traffic with held-valid bursts and occasional reset
    mode = 0;
    for (int n = 0; n < 4000; n++) begin
      logic v, r;
      if (n % 400 == 0) mode = int'($urandom_range(0, 2));
      case (mode)
        0:       v = ($urandom_range(0, 3) == 0);
        1:       v = 1'b1;
        default: v = 1'(($urandom_range(0, 1)));
      endcase
      r = ($urandom_range(0, 299) == 0);
      cyc(r, v, W'($urandom), 1'b1);
    end
    idle(2 * L + 2);
    #3;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
